// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/sequencing controller: allocates at tail, retires at head,
// and walks squashed entries youngest-first after a mispredict.
module rob_ctrl #(
  parameter int ROB_SZ = 8,
  parameter int IDX_W  = $clog2(ROB_SZ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             disp_req,
  output logic             disp_gnt,
  output logic [IDX_W-1:0] disp_idx,
  input  logic             head_done,
  output logic             retire_valid,
  output logic [IDX_W-1:0] retire_idx,
  input  logic             squash_req,
  input  logic [IDX_W-1:0] squash_idx,
  output logic             squash_ack,
  output logic             walk_valid,
  output logic [IDX_W-1:0] walk_idx,
  output logic             busy,
  output logic             full,
  output logic             empty,
  output logic [IDX_W:0]   count
);

  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] WALK   = 1'b1;

  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(ROB_SZ);
  localparam logic [IDX_W:0]   ONE_CNT  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W-1:0] wptr_q, wptr_d;
  logic [IDX_W-1:0] stop_q, stop_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [0:0]       state_q, state_d;

  logic             in_walk;
  logic [IDX_W-1:0] off;
  logic             off_valid;
  logic             off_youngest;
  logic             start_walk;

  assign in_walk      = (state_q == WALK);
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign busy         = in_walk;
  assign walk_valid   = in_walk;
  assign walk_idx     = wptr_q;
  assign disp_idx     = tail_q;
  assign retire_idx   = head_q;

  assign retire_valid = head_done & ~empty;
  assign disp_gnt     = disp_req & ~full & ~squash_req & ~in_walk;
  assign squash_ack   = squash_req & ~in_walk;

  // Branch age relative to the pre-retire head; only a branch with younger entries walks.
  assign off          = squash_idx - head_q;
  assign off_valid    = ({1'b0, off} < count_q);
  assign off_youngest = ({1'b0, off} == (count_q - ONE_CNT));
  assign start_walk   = squash_ack & off_valid & ~off_youngest;

  always_comb begin
    head_d  = head_q + IDX_W'(retire_valid);
    tail_d  = tail_q;
    wptr_d  = wptr_q;
    stop_d  = stop_q;
    state_d = state_q;
    count_d = count_q + (IDX_W+1)'(disp_gnt)
                      - (IDX_W+1)'(retire_valid)
                      - (IDX_W+1)'(in_walk);
    if (in_walk) begin
      tail_d = wptr_q;
      if (wptr_q == stop_q + ONE_IDX) begin
        state_d = NORMAL;
      end else begin
        wptr_d = wptr_q - ONE_IDX;
      end
    end else begin
      if (disp_gnt) begin
        tail_d = tail_q + ONE_IDX;
      end
      if (start_walk) begin
        wptr_d  = tail_q - ONE_IDX;
        stop_d  = squash_idx;
        state_d = WALK;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      wptr_q  <= '0;
      stop_q  <= '0;
      count_q <= '0;
      state_q <= NORMAL;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      wptr_q  <= wptr_d;
      stop_q  <= stop_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: queue-based ROB model compared every cycle, plus directed
// scenarios with literal expectations.
module tb_rob_ctrl;
  localparam int N = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       disp_req = 1'b0;
  logic       head_done = 1'b0;
  logic       squash_req = 1'b0;
  logic [2:0] squash_idx = '0;
  logic       disp_gnt, retire_valid, squash_ack, walk_valid, busy, full, empty;
  logic [2:0] disp_idx, retire_idx, walk_idx;
  logic [3:0] count;

  rob_ctrl #(.ROB_SZ(N)) dut (
    .clock(clock), .reset(reset),
    .disp_req(disp_req), .disp_gnt(disp_gnt), .disp_idx(disp_idx),
    .head_done(head_done), .retire_valid(retire_valid), .retire_idx(retire_idx),
    .squash_req(squash_req), .squash_idx(squash_idx), .squash_ack(squash_ack),
    .walk_valid(walk_valid), .walk_idx(walk_idx), .busy(busy),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Model: head/tail/occupancy as integers, pending undo list as a queue.
  int m_head = 0, m_tail = 0, m_count = 0;
  int wq[$];
  logic e_gnt = 1'b0, e_ret = 1'b0, e_ack = 1'b0, e_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_count = 0;
    wq.delete();
  endtask

  always @(negedge reset) model_reset();

  always @(negedge clock) begin
    e_busy = reset && (wq.size() != 0);
    e_ret  = reset && head_done && (m_count != 0);
    e_gnt  = reset && disp_req && (m_count != N) && !squash_req && !e_busy;
    e_ack  = reset && squash_req && !e_busy;
    chk("disp_gnt", disp_gnt, e_gnt);
    chk("disp_idx", disp_idx, m_tail);
    chk("retire_valid", retire_valid, e_ret);
    chk("retire_idx", retire_idx, m_head);
    chk("squash_ack", squash_ack, e_ack);
    chk("walk_valid", walk_valid, e_busy);
    chk("busy", busy, e_busy);
    chk("full", full, m_count == N);
    chk("empty", empty, m_count == 0);
    chk("count", count, m_count);
    if (e_busy) chk("walk_idx", walk_idx, wq[0]);
    if (!reset) chk("walk_idx_rst", walk_idx, 0);
  end

  always @(posedge clock) begin
    if (reset) begin
      if (e_ack) begin
        int off;
        off = (int'(squash_idx) - m_head) & (N-1);
        if (off < m_count && off != m_count - 1)
          for (int k = 1; k <= m_count - 1 - off; k++) wq.push_back((m_tail - k) & (N-1));
      end else if (e_busy) begin
        m_tail = wq.pop_front();
        m_count--;
      end
      if (e_gnt) begin m_tail = (m_tail + 1) % N; m_count++; end
      if (e_ret) begin m_head = (m_head + 1) % N; m_count--; end
    end
  end

  task automatic step(input logic dr, input logic hd, input logic sr, input logic [2:0] si);
    @(posedge clock); #1;
    disp_req = dr; head_done = hd; squash_req = sr; squash_idx = si;
    @(negedge clock); #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    disp_req = 0; head_done = 0; squash_req = 0; squash_idx = 0;
    reset = 0;
    @(posedge clock); #1;
    reset = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    @(posedge clock); #1;
    reset = 1;

    // Fill and drain
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      chk("fill_idx", disp_idx, i);
      chk("fill_gnt", disp_gnt, 1);
    end
    step(1, 0, 0, 0);
    chk("fill_full", full, 1);
    chk("ninth_rej", disp_gnt, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      chk("drain_idx", retire_idx, i);
      chk("drain_valid", retire_valid, 1);
    end
    step(0, 0, 0, 0);
    chk("drained_empty", empty, 1);

    // Wrap-around
    repeat (6) step(1, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      chk("wrap_idx", disp_idx, (6 + i) % 8);
    end
    step(0, 0, 0, 0);
    chk("wrap_count", count, 5);
    chk("wrap_tail", disp_idx, 3);
    chk("model_tail", m_tail, 3);

    // Squash walk: head 0, tail 6, branch 2
    do_reset();
    repeat (6) step(1, 0, 0, 0);
    step(0, 0, 1, 2);
    chk("sq_ack", squash_ack, 1);
    chk("sq_nowalk", walk_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("walk_v", walk_valid, 1);
      chk("walk_idx_seq", walk_idx, 5 - i);
      chk("walk_nodisp", disp_gnt, 0);
    end
    step(1, 0, 0, 0);
    chk("post_walk_gnt", disp_gnt, 1);
    chk("post_walk_idx", disp_idx, 3);
    chk("post_walk_cnt", count, 3);
    chk("model_cnt", m_count, 3);

    // Youngest and invalid squash
    repeat (2) step(1, 0, 0, 0);
    step(0, 0, 1, 5);
    chk("young_ack", squash_ack, 1);
    step(0, 0, 0, 0);
    chk("young_nowalk", walk_valid, 0);
    chk("young_cnt", count, 6);
    step(0, 0, 1, 7);
    chk("inv_ack", squash_ack, 1);
    step(0, 0, 0, 0);
    chk("inv_nowalk", walk_valid, 0);
    chk("inv_cnt", count, 6);
    chk("inv_tail", disp_idx, 6);

    // Request held through its own walk, re-acked afterwards as youngest
    step(0, 0, 1, 3);
    chk("hold_ack0", squash_ack, 1);
    step(0, 0, 1, 3);
    chk("hold_noack1", squash_ack, 0);
    chk("hold_widx1", walk_idx, 5);
    step(0, 0, 1, 3);
    chk("hold_noack2", squash_ack, 0);
    chk("hold_widx2", walk_idx, 4);
    step(0, 0, 1, 3);
    chk("hold_reack", squash_ack, 1);
    chk("hold_idle", walk_valid, 0);
    step(0, 0, 0, 0);
    chk("hold_cnt", count, 4);

    // Simultaneous events
    repeat (4) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sim_full", full, 1);
    step(1, 1, 0, 0);
    chk("sim_ret", retire_valid, 1);
    chk("sim_nogrant", disp_gnt, 0);
    step(0, 0, 0, 0);
    chk("sim_cnt7", count, 7);
    step(0, 0, 1, 3);
    chk("sim_sq_ack", squash_ack, 1);
    step(0, 1, 0, 0);
    chk("sim_walk_ret", retire_valid, 1);
    chk("sim_walk_v", walk_valid, 1);
    chk("sim_walk_i", walk_idx, 7);
    step(0, 0, 0, 0);
    chk("sim_drop2", count, 5);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sim_last_walk", walk_idx, 4);
    step(0, 0, 0, 0);
    chk("sim_end_cnt", count, 2);
    chk("sim_end_tail", disp_idx, 4);
    chk("sim_end_head", retire_idx, 2);

    // Reset mid-walk
    repeat (4) step(1, 0, 0, 0);
    step(0, 0, 1, 2);
    step(0, 0, 0, 0);
    chk("rw_w1", walk_idx, 7);
    step(0, 0, 0, 0);
    chk("rw_w2_v", walk_valid, 1);
    chk("rw_w2_i", walk_idx, 6);
    reset = 0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_wv", walk_valid, 0);
    chk("rw_cnt", count, 0);
    chk("rw_empty", empty, 1);
    chk("rw_tail", disp_idx, 0);
    chk("rw_head", retire_idx, 0);
    repeat (2) begin
      @(negedge clock); #1;
      chk("rw_no_pulse", walk_valid, 0);
    end
    @(posedge clock); #1;
    reset = 1;
    step(1, 0, 0, 0);
    chk("rw_gnt", disp_gnt, 1);
    chk("rw_idx", disp_idx, 0);
    step(0, 0, 0, 0);
    chk("rw_cnt1", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
